scalar_reg_file_mw: RTL and testbench

Multi-warp scalar register file. One physical array holds NUM_WARPS x NUM_REGS words, sized to map onto block RAM. It provides two synchronous read ports, one write port with the existing reg_input_mux_t source select, and a per-register pending scoreboard for outstanding LSU loads. It sits between the warp scheduler/decoder and the scalar execute stage, and exports each warp's execution mask (register NUM_REGS-1).

---
 rtl/scalar_reg_file_mw_pkg.sv | 35 +++
 rtl/scalar_reg_file_mw_scoreboard.sv | 36 +++
 rtl/scalar_reg_file_mw.sv | 193 +++++++++++++++++++
 tb/tb_scalar_reg_file_mw.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/scalar_reg_file_mw_pkg.sv
// rtl/scalar_reg_file_mw_pkg.sv - shared types and constants for the multi-warp scalar register file
package scalar_reg_file_mw_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int IMEM_ADDR_W    = 16;

   typedef logic [IMEM_ADDR_W-1:0] instruction_memory_address_t;

   typedef enum logic [2:0] {
      ALU_OUT          = 3'd0,
      LSU_OUT          = 3'd1,
      IMMEDIATE        = 3'd2,
      PC_PLUS_1        = 3'd3,
      VECTOR_TO_SCALAR = 3'd4
   } reg_input_mux_t;

   typedef enum logic {
      RF_INIT = 1'b0,
      RF_RUN  = 1'b1
   } rf_state_t;

   // Which source the registered read output is taken from.
   typedef enum logic [1:0] {
      RD_ZERO = 2'd0,
      RD_MEM  = 2'd1,
      RD_BYP  = 2'd2
   } rd_src_t;

   localparam int ZERO_REG = 0;

   function automatic int exec_mask_reg(input int num_regs);
      return num_regs - 1;
   endfunction

endpackage

// File: rtl/scalar_reg_file_mw_scoreboard.sv
// rtl/scalar_reg_file_mw_scoreboard.sv - per-register pending-load bits with post-update lookups
module reg_scoreboard #(
   parameter int DEPTH = 128,
   parameter int IDX_W = 7
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             set_en_i,
   input  logic [IDX_W-1:0] set_idx_i,
   input  logic             clr_en_i,
   input  logic [IDX_W-1:0] clr_idx_i,
   input  logic [IDX_W-1:0] lk1_idx_i,
   input  logic [IDX_W-1:0] lk2_idx_i,
   output logic             lk1_pending_o,
   output logic             lk2_pending_o
);

   logic [DEPTH-1:0] sb_q;
   logic [DEPTH-1:0] sb_d;

   // Set is applied after clear so an issue and a writeback to the same register leave it pending.
   always_comb begin
      sb_d = sb_q;
      if (clr_en_i) sb_d[clr_idx_i] = 1'b0;
      if (set_en_i) sb_d[set_idx_i] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) sb_q <= '0;
      else         sb_q <= sb_d;
   end

   assign lk1_pending_o = sb_d[lk1_idx_i];
   assign lk2_pending_o = sb_d[lk2_idx_i];

endmodule

// File: rtl/scalar_reg_file_mw.sv
// rtl/scalar_reg_file_mw.sv - multi-warp scalar register file: 2R/1W array, init sweep, load scoreboard, exec masks
module scalar_reg_file_mw
   import scalar_reg_file_mw_pkg::*;
#(
   parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int  NUM_WARPS  = 4,
   parameter int  NUM_REGS   = 32,
   localparam int WARP_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
   localparam int REG_W      = $clog2(NUM_REGS)
) (
   input  logic                            clk,
   input  logic                            reset,
   output logic                            ready,
   input  logic                            rd_en,
   input  logic [WARP_W-1:0]               rd_warp,
   input  logic [REG_W-1:0]                rs1_addr,
   input  logic [REG_W-1:0]                rs2_addr,
   output logic                            rd_valid,
   output logic [DATA_WIDTH-1:0]           rs1_data,
   output logic [DATA_WIDTH-1:0]           rs2_data,
   output logic                            rs1_pending,
   output logic                            rs2_pending,
   input  logic                            wr_en,
   input  logic [WARP_W-1:0]               wr_warp,
   input  logic [REG_W-1:0]                wr_addr,
   input  reg_input_mux_t                  wr_mux,
   input  logic [DATA_WIDTH-1:0]           alu_out,
   input  logic [DATA_WIDTH-1:0]           lsu_out,
   input  logic [DATA_WIDTH-1:0]           immediate,
   input  instruction_memory_address_t     pc,
   input  logic [DATA_WIDTH-1:0]           vector_to_scalar_data,
   input  logic                            sb_set_en,
   input  logic [WARP_W-1:0]               sb_set_warp,
   input  logic [REG_W-1:0]                sb_set_addr,
   output logic [NUM_WARPS*DATA_WIDTH-1:0] exec_mask,
   output logic                            wr_error
);

   localparam int IDX_W = WARP_W + REG_W;
   localparam int DEPTH = NUM_WARPS * NUM_REGS;
   localparam int EMR   = exec_mask_reg(NUM_REGS);

   function automatic logic warp_in_range(input logic [WARP_W-1:0] w);
      return 32'(w) < NUM_WARPS;
   endfunction

   rf_state_t             state_q;
   logic [IDX_W-1:0]      init_cnt_q;
   logic                  ready_q;
   logic                  rd_valid_q;
   rd_src_t               sel1_q, sel2_q, sel1_d, sel2_d;
   logic                  pend1_q, pend2_q, pend1_d, pend2_d;
   logic [DATA_WIDTH-1:0] byp_data_q;
   logic [DATA_WIDTH-1:0] mem_rd1_q, mem_rd2_q;
   logic                  wr_error_q;
   logic [DATA_WIDTH-1:0] exec_mask_q [NUM_WARPS];
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  run, rd_fire, wr_fire, wr_mux_ok, sb_set_ok;
   logic                  rd_warp_ok, wr_warp_ok;
   logic [IDX_W-1:0]      rd1_idx, rd2_idx, wr_idx, sb_idx;
   logic [DATA_WIDTH-1:0] wr_data, init_word;
   logic                  mem_we;
   logic [IDX_W-1:0]      mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  sb_pend1, sb_pend2;

   assign run        = (state_q == RF_RUN);
   assign rd_warp_ok = warp_in_range(rd_warp);
   assign wr_warp_ok = warp_in_range(wr_warp);
   assign rd1_idx    = {rd_warp, rs1_addr};
   assign rd2_idx    = {rd_warp, rs2_addr};
   assign wr_idx     = {wr_warp, wr_addr};
   assign sb_idx     = {sb_set_warp, sb_set_addr};

   always_comb begin
      wr_data   = '0;
      wr_mux_ok = 1'b1;
      case (wr_mux)
         ALU_OUT:          wr_data = alu_out;
         LSU_OUT:          wr_data = lsu_out;
         IMMEDIATE:        wr_data = immediate;
         PC_PLUS_1:        wr_data = DATA_WIDTH'(pc) + DATA_WIDTH'(1);
         VECTOR_TO_SCALAR: wr_data = vector_to_scalar_data;
         default:          wr_mux_ok = 1'b0;
      endcase
   end

   assign rd_fire   = run && rd_en;
   assign wr_fire   = run && wr_en && wr_warp_ok && wr_mux_ok && (wr_addr != REG_W'(ZERO_REG));
   assign sb_set_ok = run && sb_set_en && warp_in_range(sb_set_warp)
                      && (sb_set_addr != REG_W'(ZERO_REG));

   // The init sweep owns the single write port until the array is populated.
   assign init_word = (init_cnt_q[REG_W-1:0] == REG_W'(1) || init_cnt_q[REG_W-1:0] == REG_W'(EMR))
                      ? '1 : '0;
   assign mem_we    = run ? wr_fire : 1'b1;
   assign mem_waddr = run ? wr_idx  : init_cnt_q;
   assign mem_wdata = run ? wr_data : init_word;

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      if (rd_fire) begin
         mem_rd1_q <= mem[rd1_idx];
         mem_rd2_q <= mem[rd2_idx];
      end
   end

   reg_scoreboard #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_scoreboard (
      .clk_i         (clk),
      .reset_i       (reset),
      .set_en_i      (sb_set_ok),
      .set_idx_i     (sb_idx),
      .clr_en_i      (wr_fire && (wr_mux == LSU_OUT)),
      .clr_idx_i     (wr_idx),
      .lk1_idx_i     (rd1_idx),
      .lk2_idx_i     (rd2_idx),
      .lk1_pending_o (sb_pend1),
      .lk2_pending_o (sb_pend2)
   );

   always_comb begin
      sel1_d  = RD_MEM;
      sel2_d  = RD_MEM;
      pend1_d = sb_pend1;
      pend2_d = sb_pend2;
      if (!rd_warp_ok || rs1_addr == REG_W'(ZERO_REG)) begin
         sel1_d  = RD_ZERO;
         pend1_d = 1'b0;
      end else if (wr_fire && wr_idx == rd1_idx) begin
         sel1_d  = RD_BYP;
      end
      if (!rd_warp_ok || rs2_addr == REG_W'(ZERO_REG)) begin
         sel2_d  = RD_ZERO;
         pend2_d = 1'b0;
      end else if (wr_fire && wr_idx == rd2_idx) begin
         sel2_d  = RD_BYP;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RF_INIT;
         init_cnt_q <= '0;
         ready_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         sel1_q     <= RD_ZERO;
         sel2_q     <= RD_ZERO;
         pend1_q    <= 1'b0;
         pend2_q    <= 1'b0;
         byp_data_q <= '0;
         wr_error_q <= 1'b0;
         for (int w = 0; w < NUM_WARPS; w++) exec_mask_q[w] <= '1;
      end else begin
         case (state_q)
            RF_INIT: begin
               init_cnt_q <= init_cnt_q + IDX_W'(1);
               if (init_cnt_q == IDX_W'(DEPTH - 1)) begin
                  state_q <= RF_RUN;
                  ready_q <= 1'b1;
               end
            end
            default: ;
         endcase
         rd_valid_q <= rd_fire;
         if (rd_fire) begin
            sel1_q     <= sel1_d;
            sel2_q     <= sel2_d;
            pend1_q    <= pend1_d;
            pend2_q    <= pend2_d;
            byp_data_q <= wr_data;
         end
         if (run && wr_en && !wr_mux_ok) wr_error_q <= 1'b1;
         if (wr_fire && wr_addr == REG_W'(EMR)) exec_mask_q[wr_warp] <= wr_data;
      end
   end

   assign ready       = ready_q;
   assign rd_valid    = rd_valid_q;
   assign rs1_data    = (sel1_q == RD_BYP) ? byp_data_q : (sel1_q == RD_MEM) ? mem_rd1_q : '0;
   assign rs2_data    = (sel2_q == RD_BYP) ? byp_data_q : (sel2_q == RD_MEM) ? mem_rd2_q : '0;
   assign rs1_pending = pend1_q;
   assign rs2_pending = pend2_q;
   assign wr_error    = wr_error_q;

   for (genvar w = 0; w < NUM_WARPS; w++) begin : g_mask
      assign exec_mask[w*DATA_WIDTH +: DATA_WIDTH] = exec_mask_q[w];
   end

endmodule

// File: tb/tb_scalar_reg_file_mw.sv
// tb/tb_scalar_reg_file_mw.sv - directed bench with an array-level reference model for scalar_reg_file_mw
module tb_scalar_reg_file_mw;
   import scalar_reg_file_mw_pkg::*;

   localparam int DW = 32;
   localparam int NW = 4;
   localparam int NR = 32;

   logic                        clk = 1'b0;
   logic                        reset;
   logic                        ready, rd_valid, rs1_pending, rs2_pending, wr_error;
   logic                        rd_en, wr_en, sb_set_en;
   logic [1:0]                  rd_warp, wr_warp, sb_set_warp;
   logic [4:0]                  rs1_addr, rs2_addr, wr_addr, sb_set_addr;
   logic [DW-1:0]               rs1_data, rs2_data, alu_out, lsu_out, immediate, v2s;
   reg_input_mux_t              wr_mux;
   instruction_memory_address_t pc;
   logic [NW*DW-1:0]            exec_mask;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] m_rf   [NW][NR];
   bit            m_pend [NW][NR];
   logic [DW-1:0] m_mask [NW];
   bit            m_err, m_ready;
   int            m_left;

   bit            chk_on = 0;
   bit            e_ready, e_valid, e_p1, e_p2, e_err;
   logic [DW-1:0] e_rs1, e_rs2;
   logic [NW*DW-1:0] e_mask;

   always #5 clk = ~clk;

   scalar_reg_file_mw #(.DATA_WIDTH(DW), .NUM_WARPS(NW), .NUM_REGS(NR)) dut (
      .clk(clk), .reset(reset), .ready(ready),
      .rd_en(rd_en), .rd_warp(rd_warp), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rd_valid(rd_valid), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
      .wr_en(wr_en), .wr_warp(wr_warp), .wr_addr(wr_addr), .wr_mux(wr_mux),
      .alu_out(alu_out), .lsu_out(lsu_out), .immediate(immediate), .pc(pc),
      .vector_to_scalar_data(v2s),
      .sb_set_en(sb_set_en), .sb_set_warp(sb_set_warp), .sb_set_addr(sb_set_addr),
      .exec_mask(exec_mask), .wr_error(wr_error)
   );

   task automatic check(input string name, input logic [NW*DW-1:0] got, input logic [NW*DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check("ready", ready, e_ready);
         check("rd_valid", rd_valid, e_valid);
         check("rs1_data", rs1_data, e_rs1);
         check("rs2_data", rs2_data, e_rs2);
         check("wr_error", wr_error, e_err);
         check("exec_mask", exec_mask, e_mask);
         if (e_valid) begin
            check("rs1_pending", rs1_pending, e_p1);
            check("rs2_pending", rs2_pending, e_p2);
         end
      end
   end

   // Model: apply this cycle's write and pending set first, then read, which yields bypass semantics.
   task automatic tick();
      logic [DW-1:0] n_rs1, n_rs2, d;
      bit n_p1, n_p2, n_v;
      n_rs1 = e_rs1; n_rs2 = e_rs2; n_p1 = e_p1; n_p2 = e_p2; n_v = 0;
      if (reset) begin
         for (int w = 0; w < NW; w++) begin
            for (int r = 0; r < NR; r++) begin
               m_rf[w][r]   = (r == 1 || r == NR - 1) ? '1 : '0;
               m_pend[w][r] = 0;
            end
            m_mask[w] = '1;
         end
         m_err = 0; m_ready = 0; m_left = NW * NR;
         n_rs1 = 0; n_rs2 = 0; n_p1 = 0; n_p2 = 0;
      end else if (!m_ready) begin
         m_left--;
         if (m_left == 0) m_ready = 1;
      end else begin
         if (wr_en) begin
            if (int'(wr_mux) > 4) m_err = 1;
            else if (wr_addr != 0) begin
               case (int'(wr_mux))
                  0: d = alu_out;
                  1: d = lsu_out;
                  2: d = immediate;
                  3: d = 32'(pc) + 32'd1;
                  default: d = v2s;
               endcase
               m_rf[wr_warp][wr_addr] = d;
               if (wr_addr == NR - 1) m_mask[wr_warp] = d;
               if (wr_mux == LSU_OUT) m_pend[wr_warp][wr_addr] = 0;
            end
         end
         if (sb_set_en && sb_set_addr != 0) m_pend[sb_set_warp][sb_set_addr] = 1;
         if (rd_en) begin
            n_v   = 1;
            n_rs1 = (rs1_addr == 0) ? '0 : m_rf[rd_warp][rs1_addr];
            n_rs2 = (rs2_addr == 0) ? '0 : m_rf[rd_warp][rs2_addr];
            n_p1  = (rs1_addr == 0) ? 0 : m_pend[rd_warp][rs1_addr];
            n_p2  = (rs2_addr == 0) ? 0 : m_pend[rd_warp][rs2_addr];
         end
      end
      @(posedge clk);
      #1;
      e_rs1 = n_rs1; e_rs2 = n_rs2; e_p1 = n_p1; e_p2 = n_p2; e_valid = n_v;
      e_ready = m_ready; e_err = m_err;
      for (int w = 0; w < NW; w++) e_mask[w*DW +: DW] = m_mask[w];
      chk_on = 1;
      @(negedge clk);
   endtask

   task automatic idle();
      rd_en = 0; wr_en = 0; sb_set_en = 0;
      rd_warp = 0; rs1_addr = 0; rs2_addr = 0;
      wr_warp = 0; wr_addr = 0; wr_mux = ALU_OUT;
      alu_out = 0; lsu_out = 0; immediate = 0; v2s = 0; pc = 0;
      sb_set_warp = 0; sb_set_addr = 0;
   endtask

   task automatic set_rd(input int w, input int a1, input int a2);
      rd_en = 1; rd_warp = 2'(w); rs1_addr = 5'(a1); rs2_addr = 5'(a2);
   endtask

   task automatic set_wr(input int w, input int a, input reg_input_mux_t m, input logic [DW-1:0] d);
      wr_en = 1; wr_warp = 2'(w); wr_addr = 5'(a); wr_mux = m;
      alu_out = d; lsu_out = d; immediate = d; v2s = d;
   endtask

   task automatic set_sb(input int w, input int a);
      sb_set_en = 1; sb_set_warp = 2'(w); sb_set_addr = 5'(a);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      reset = 1;
      @(negedge clk);
      tick();
      reset = 0;
      check("rst_ready", ready, 1'b0);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_rs1", rs1_data, 32'h0);
      check("rst_mask", exec_mask, {NW*DW{1'b1}});

      repeat (NW * NR - 1) tick();
      check("ready_before_sweep_end", ready, 1'b0);
      tick();
      check("ready_after_sweep", ready, 1'b1);

      set_rd(2, 1, 31); tick(); idle();
      check("w2_r1", rs1_data, 32'hFFFF_FFFF);
      check("w2_r31", rs2_data, 32'hFFFF_FFFF);
      set_rd(2, 5, 0); tick(); idle();
      check("w2_r5", rs1_data, 32'h0);

      set_rd(1, 7, 0); set_wr(1, 7, IMMEDIATE, 32'h1234); tick(); idle();
      check("bypass_rs1", rs1_data, 32'h1234);
      check("bypass_rs2_r0", rs2_data, 32'h0);
      set_rd(0, 7, 7); tick(); idle();
      check("w0_r7", rs1_data, 32'h0);
      tick();
      set_rd(1, 7, 1); tick(); idle();

      set_wr(3, 31, ALU_OUT, 32'h0000_000F); tick(); idle();
      check("mask_w3", exec_mask[3*DW +: DW], 32'h0000_000F);
      check("mask_w0", exec_mask[0 +: DW], 32'hFFFF_FFFF);

      set_sb(0, 4); tick(); idle();
      set_rd(0, 4, 0); tick(); idle();
      check("pend_set", rs1_pending, 1'b1);
      set_wr(0, 4, ALU_OUT, 32'h5); set_rd(0, 4, 0); tick(); idle();
      check("pend_alu_keeps", rs1_pending, 1'b1);
      set_wr(0, 4, LSU_OUT, 32'hDEAD); set_rd(0, 4, 0); tick(); idle();
      check("pend_lsu_clr", rs1_pending, 1'b0);
      check("lsu_data", rs1_data, 32'hDEAD);
      set_sb(0, 4); set_wr(0, 4, LSU_OUT, 32'hBEEF); set_rd(0, 4, 4); tick(); idle();
      check("pend_set_wins", rs1_pending, 1'b1);
      set_sb(2, 0); set_rd(2, 0, 0); tick(); idle();
      check("pend_r0", rs1_pending, 1'b0);

      set_wr(0, 9, PC_PLUS_1, 32'h0); pc = 16'h003F; tick(); idle();
      set_rd(0, 9, 0); tick(); idle();
      check("pc_plus_1", rs1_data, 32'h40);
      set_wr(0, 9, reg_input_mux_t'(3'd6), 32'h777); tick(); idle();
      check("wr_error_set", wr_error, 1'b1);
      set_rd(0, 9, 0); tick(); idle();
      check("invalid_no_write", rs1_data, 32'h40);
      set_wr(0, 0, IMMEDIATE, 32'h99); set_rd(0, 0, 9); tick(); idle();
      check("r0_dropped", rs1_data, 32'h0);
      tick(); tick();

      for (int i = 0; i < 8; i++) begin
         set_wr(i % NW, 10 + i, (i % 2) ? VECTOR_TO_SCALAR : ALU_OUT, 32'hA000_0000 + 32'(i * 3));
         set_rd((i + 1) % NW, 10 + i, 9 + i);
         tick(); idle();
      end
      for (int i = 0; i < 8; i++) begin
         set_rd(i % NW, 10 + i, 31); tick(); idle();
      end

      reset = 1; tick(); reset = 0;
      set_wr(1, 7, IMMEDIATE, 32'h5555); set_rd(1, 7, 4); set_sb(0, 6);
      repeat (10) tick();
      reset = 1; tick(); reset = 0;
      check("restart_ready", ready, 1'b0);
      check("restart_err_clr", wr_error, 1'b0);
      repeat (NW * NR) tick();
      idle();
      check("restart_ready_done", ready, 1'b1);
      check("init_no_rd_valid", rd_valid, 1'b0);
      check("restart_mask", exec_mask, {NW*DW{1'b1}});
      set_rd(1, 7, 9); tick(); idle();
      check("init_write_ignored", rs1_data, 32'h0);
      set_rd(0, 6, 4); tick(); idle();
      check("init_sb_ignored", rs1_pending, 1'b0);
      check("restart_pend_clr", rs2_pending, 1'b0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
